// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: next-PC selection, branch-target LUT and the
// idle/launch/run/done program-run FSM. Define REL_BRANCH_EN for PC-relative branch targets.
module pc_seq_ctrl #(
  parameter int unsigned      PC_W      = 12,
  parameter int unsigned      LUT_DEPTH = 32,
  parameter logic [PC_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned      CNT_W     = 16,
  localparam int unsigned     IDX_W     = $clog2(LUT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [PC_W-1:0]  pc_cur,
  input  logic             branch_taken,
  input  logic [IDX_W-1:0] branch_idx,
  input  logic             halt,
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  pc_next,
  output logic             start,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   lut_q [LUT_DEPTH];
  logic [PC_W-1:0]   lut_rd;
  logic [PC_W-1:0]   branch_tgt;
  logic [PC_W-1:0]   pc_inc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; go only matters in IDLE and DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (go) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN:    if (halt) state_d = ST_DONE;
      ST_DONE:   if (go) state_d = ST_LAUNCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs and next-address selection; halt outranks a taken branch
  always_comb begin
    start   = 1'b0;
    done    = 1'b0;
    pc_next = pc_cur;
    case (state_q)
      ST_IDLE:   start = 1'b1;
      ST_LAUNCH: pc_next = BASE_ADDR;
      ST_RUN: begin
        if (halt) begin
          pc_next = pc_cur;
        end else if (branch_taken) begin
          pc_next = branch_tgt;
        end else begin
          pc_next = pc_inc;
        end
      end
      ST_DONE:   done = 1'b1;
      default:   start = 1'b1;
    endcase
  end

  // Branch-target LUT: write lands at the edge, so a same-cycle read sees the old entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(LUT_DEPTH); i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign lut_rd = lut_q[branch_idx];
  assign pc_inc = pc_cur + PC_W'(1);

`ifdef REL_BRANCH_EN
  assign branch_tgt = pc_cur + lut_rd;
`else
  assign branch_tgt = lut_rd;
`endif

  // RUN-cycle counter, cleared on launch and saturating at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed self-checking bench for pc_seq_ctrl; expected branch targets follow
// the REL_BRANCH_EN setting of the build.
module tb_pc_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        go;
  logic [11:0] pc_cur;
  logic        branch_taken;
  logic [4:0]  branch_idx;
  logic        halt;
  logic        lut_we;
  logic [4:0]  lut_waddr;
  logic [11:0] lut_wdata;
  logic [11:0] pc_next;
  logic        start;
  logic        done;
  logic [15:0] cycle_count;

  int total = 0;
  int bad   = 0;
  int nrun  = 0;

  pc_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .pc_cur       (pc_cur),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .halt         (halt),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .pc_next      (pc_next),
    .start        (start),
    .done         (done),
    .cycle_count  (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pc_cur = 12'h123;
    #3;
    total++; if (start !== 1'b1) begin bad++; $display("FAIL rst_start got=%b exp=1", start); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cycle_count); end
    total++; if (pc_next !== 12'h123) begin bad++; $display("FAIL rst_pcnext got=%h exp=123", pc_next); end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_launch();
    go = 1'b1;
    #1;
    total++; if (pc_next !== 12'h123 || start !== 1'b1) begin bad++; $display("FAIL idle_hold got=%h/%b exp=123/1", pc_next, start); end
    tick();
    go = 1'b0;
    #1;
    total++; if (start !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL launch_flags got=%b%b exp=00", start, done); end
    total++; if (pc_next !== 12'h000) begin bad++; $display("FAIL launch_pc got=%h exp=000", pc_next); end
    tick();
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL run_first_cnt got=%0d exp=0", cycle_count); end
    for (int i = 0; i < 3; i++) begin
      pc_cur = 12'(i);
      go = (i == 1);
      #1;
      total++; if (pc_next !== 12'(i + 1)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc_next, 12'(i + 1)); end
      total++; if (done !== 1'b0 || start !== 1'b0) begin bad++; $display("FAIL seq_flags%0d got=%b%b exp=00", i, start, done); end
      tick();
      nrun++;
    end
    go = 1'b0;
  endtask

  task automatic test_branch();
    logic [11:0] exp1, exp2;
`ifdef REL_BRANCH_EN
    exp1 = 12'h0B0; exp2 = 12'h000;
`else
    exp1 = 12'h0A0; exp2 = 12'hFF0;
`endif
    pc_cur = 12'h003; lut_we = 1'b1; lut_waddr = 5'd5; lut_wdata = 12'h0A0;
    tick(); nrun++;
    lut_we = 1'b0;
    pc_cur = 12'h010; branch_taken = 1'b1; branch_idx = 5'd5;
    #1;
    total++; if (pc_next !== exp1) begin bad++; $display("FAIL branch_a got=%h exp=%h", pc_next, exp1); end
    tick(); nrun++;
    branch_taken = 1'b0; lut_we = 1'b1; lut_wdata = 12'hFF0;
    tick(); nrun++;
    lut_we = 1'b0; branch_taken = 1'b1;
    #1;
    total++; if (pc_next !== exp2) begin bad++; $display("FAIL branch_b got=%h exp=%h", pc_next, exp2); end
    tick(); nrun++;
    branch_taken = 1'b0;
  endtask

  task automatic test_wrap();
    pc_cur = 12'hFFF;
    #1;
    total++; if (pc_next !== 12'h000) begin bad++; $display("FAIL wrap got=%h exp=000", pc_next); end
    tick(); nrun++;
  endtask

  task automatic test_same_cycle_write();
    logic [11:0] exp_old, exp_new;
`ifdef REL_BRANCH_EN
    exp_old = 12'h232; exp_new = 12'h121;
`else
    exp_old = 12'h222; exp_new = 12'h111;
`endif
    pc_cur = 12'h004; lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 12'h222;
    tick(); nrun++;
    pc_cur = 12'h010; lut_wdata = 12'h111; branch_taken = 1'b1; branch_idx = 5'd3;
    #1;
    total++; if (pc_next !== exp_old) begin bad++; $display("FAIL rw_old got=%h exp=%h", pc_next, exp_old); end
    tick(); nrun++;
    lut_we = 1'b0;
    #1;
    total++; if (pc_next !== exp_new) begin bad++; $display("FAIL rw_new got=%h exp=%h", pc_next, exp_new); end
    tick(); nrun++;
    branch_taken = 1'b0;
  endtask

  task automatic test_halt();
    halt = 1'b1; branch_taken = 1'b1; branch_idx = 5'd3; pc_cur = 12'h020;
    #1;
    total++; if (pc_next !== 12'h020) begin bad++; $display("FAIL halt_pc got=%h exp=020", pc_next); end
    tick(); nrun++;
    halt = 1'b0; branch_taken = 1'b0;
    #1;
    total++; if (done !== 1'b1 || start !== 1'b0) begin bad++; $display("FAIL halt_flags got=%b%b exp=01", start, done); end
    total++; if (cycle_count !== 16'(nrun)) begin bad++; $display("FAIL halt_cnt got=%0d exp=%0d", cycle_count, nrun); end
    total++; if (pc_next !== 12'h020) begin bad++; $display("FAIL done_hold got=%h exp=020", pc_next); end
    go = 1'b1;
    tick();
    go = 1'b0;
    #1;
    total++; if (pc_next !== 12'h000 || done !== 1'b0 || start !== 1'b0) begin bad++; $display("FAIL relaunch got=%h/%b%b exp=000/00", pc_next, start, done); end
    tick();
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL relaunch_cnt got=%0d exp=0", cycle_count); end
    pc_cur = 12'h000; tick();
    pc_cur = 12'h001; tick();
    pc_cur = 12'h002; halt = 1'b1; tick();
    halt = 1'b0;
    #1;
    total++; if (done !== 1'b1 || cycle_count !== 16'd3) begin bad++; $display("FAIL run2_end got=%b/%0d exp=1/3", done, cycle_count); end
  endtask

  task automatic test_reset_mid_run();
    logic [11:0] exp_br;
`ifdef REL_BRANCH_EN
    exp_br = 12'h010;
`else
    exp_br = 12'h000;
`endif
    go = 1'b1; tick(); go = 1'b0;
    tick();
    pc_cur = 12'h000; tick();
    pc_cur = 12'h001; tick();
    total++; if (cycle_count !== 16'd2) begin bad++; $display("FAIL pre_rst_cnt got=%0d exp=2", cycle_count); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (start !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%b%b exp=10", start, done); end
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", cycle_count); end
    tick();
    reset = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    tick();
    pc_cur = 12'h010; branch_taken = 1'b1; branch_idx = 5'd5;
    #1;
    total++; if (pc_next !== exp_br) begin bad++; $display("FAIL lut_cleared got=%h exp=%h", pc_next, exp_br); end
    branch_taken = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; pc_cur = '0; branch_taken = 1'b0; branch_idx = '0;
    halt = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    test_reset();
    test_launch();
    test_branch();
    test_wrap();
    test_same_cycle_write();
    test_halt();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Drives the 12-bit program counter register: generates its next-address input `pc_next` and its `start` / `done` qualifiers.
- Computes sequential, branch and restart addresses from the current PC value.
- Holds a 32-entry branch-target lookup table (LUT).
- Runs the program-run FSM: idle, launch, run, done.

Parameters:
- PC_W, 12, PC width in bits.
- LUT_DEPTH, 32, number of branch-target entries; index width is log2(LUT_DEPTH) = 5.
- BASE_ADDR, 12'h000, address loaded into the PC on every launch.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  single-cycle request to begin or restart a program run.
- pc_cur  in  PC_W  current PC register value.
- branch_taken  in  1  decoded taken branch in the current instruction.
- branch_idx  in  5  LUT index of the branch target.
- halt  in  1  decoded halt instruction in the current instruction.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  5  LUT write index.
- lut_wdata  in  PC_W  LUT write data.
- pc_next  out  PC_W  next-PC value, wired to the PC register input.
- start  out  1  PC hold qualifier: 1 means the PC does not load.
- done  out  1  run-complete flag; also holds the PC.
- cycle_count  out  CNT_W  number of RUN cycles in the last or current run.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - reset is asynchronous and active-high, and clears all state immediately.
- Reset values:
  - FSM = IDLE, start = 1, done = 0, cycle_count = 0.
  - All LUT entries = 0.
  - pc_next = pc_cur.
- FSM states, outputs and transitions:
  - IDLE: start = 1, done = 0, pc_next = pc_cur. When go = 1, go to LAUNCH.
  - LAUNCH (exactly one cycle): start = 0, done = 0, pc_next = BASE_ADDR, so the PC loads BASE_ADDR at the end of this cycle. cycle_count is cleared to 0. Always go to RUN.
  - RUN: start = 0, done = 0. Next-address selection, highest priority first:
    - halt = 1: pc_next = pc_cur (PC holds); go to DONE.
    - branch_taken = 1: pc_next = LUT[branch_idx].
    - otherwise: pc_next = pc_cur + 1, modulo 2^PC_W, so 12'hFFF wraps to 12'h000 with no flag.
    - cycle_count increments every RUN cycle, including the halt cycle.
  - DONE: start = 0, done = 1, pc_next = pc_cur. When go = 1, go to LAUNCH (restart without reset).
  - go is ignored in LAUNCH and RUN.
- Latency:
  - go sampled high in cycle N: LAUNCH is in cycle N+1, and the first RUN cycle is N+2 with pc_cur = BASE_ADDR.
  - Halt sampled in cycle M: done = 1 from cycle M+1.
- LUT:
  - Synchronous write; writes are accepted in any state.
  - Combinational read at branch_idx.
  - A write and a read of the same index in the same cycle returns the old value; the new value is visible from the next cycle.
- Simultaneous events:
  - halt together with branch_taken: halt wins.
  - reset during RUN: immediate return to IDLE with start = 1; the LUT is cleared.
- cycle_count saturates at 2^CNT_W − 1 and does not wrap.

Optional Feature:
- Macro: REL_BRANCH_EN.
- Defined: when a taken branch is selected, the LUT entry is treated as a signed two's-complement PC_W offset, and pc_next = pc_cur + LUT[branch_idx], modulo 2^PC_W.
- Undefined: the LUT entry is an absolute target, and pc_next = LUT[branch_idx].
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then go with BASE_ADDR = 0. Required response:
  - LAUNCH cycle shows start = 0 and pc_next = 0.
  - In RUN, with pc_cur = 0, 1, 2, pc_next = 1, 2, 3.
  - done stays 0.
- Write LUT[5] = 12'h0A0; in RUN drive pc_cur = 12'h010, branch_taken = 1, branch_idx = 5. Required response:
  - Absolute build: pc_next = 12'h0A0.
  - REL_BRANCH_EN build: pc_next = 12'h0B0.
  - REL_BRANCH_EN build with LUT[5] = 12'hFF0 and the same pc_cur: pc_next = 12'h000.
- In RUN drive pc_cur = 12'hFFF with no branch and no halt. Required response: pc_next = 12'h000.
- Drive halt = 1 and branch_taken = 1 together with pc_cur = 12'h020. Required response:
  - pc_next = 12'h020 in that cycle.
  - Next cycle: done = 1 and start = 0.
  - cycle_count equals the number of RUN cycles, including the halt cycle.
  - Then go = 1: one LAUNCH cycle with pc_next = BASE_ADDR and done = 0, and cycle_count reads 0 from the first RUN cycle.
- Same-cycle LUT write of index 3 (12'h111 over an old 12'h222) while reading branch_idx = 3. Required response:
  - pc_next = 12'h222 in that cycle.
  - pc_next = 12'h111 on the next taken branch to index 3.
- Assert reset in the middle of RUN, between clock edges. Required response:
  - Immediately: start = 1, done = 0, cycle_count = 0.
  - Reading LUT[5] afterwards gives 0.
